// File: rtl/operand_fetch_stage_pkg.sv
// ============================================================================
// operand_fetch_stage_pkg : shared widths for the operand fetch stage
// Revision: 1.0
// ============================================================================
`default_nettype none

package operand_fetch_stage_pkg;

    localparam int OFS_DATA_W  = 20;
    localparam int OFS_SEL_W   = 4;
    localparam int OFS_REG_CNT = 16;
    localparam int OFS_OP_W    = 5;

endpackage : operand_fetch_stage_pkg

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// reg_scoreboard : per-register pending-write flags, set beats clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
    import operand_fetch_stage_pkg::*;
#(
    parameter int SEL_W   = OFS_SEL_W,
    parameter int REG_CNT = OFS_REG_CNT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               set_i,
    input  logic [SEL_W-1:0]   set_sel_i,
    input  logic               clr_i,
    input  logic [SEL_W-1:0]   clr_sel_i,
    output logic [REG_CNT-1:0] busy_o
);

    logic [REG_CNT-1:0] busy_q;
    logic [REG_CNT-1:0] busy_d;

    // Set is applied after clear so an issue in the writeback cycle keeps the flag.
    always_comb begin
        busy_d = busy_q;
        if (clr_i) begin
            busy_d[clr_sel_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_sel_i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule : reg_scoreboard

`default_nettype wire

// File: rtl/operand_fetch_stage.sv
// ============================================================================
// operand_fetch_stage : hazard check, writeback bypass and output register
// Revision: 1.0
// ============================================================================
`default_nettype none

module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W  = OFS_DATA_W,
    parameter int SEL_W   = OFS_SEL_W,
    parameter int REG_CNT = OFS_REG_CNT,
    parameter int OP_W    = OFS_OP_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [SEL_W-1:0]   in_src1,
    input  logic [SEL_W-1:0]   in_src2,
    input  logic               in_use1,
    input  logic               in_use2,
    input  logic [SEL_W-1:0]   in_dst,
    input  logic               in_wdst,
    output logic [SEL_W-1:0]   r1_select,
    output logic [SEL_W-1:0]   r2_select,
    input  logic [DATA_W-1:0]  read1,
    input  logic [DATA_W-1:0]  read2,
    input  logic               wb_w,
    input  logic [SEL_W-1:0]   wb_select,
    input  logic [DATA_W-1:0]  wb_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OP_W-1:0]    out_op,
    output logic [SEL_W-1:0]   out_dst,
    output logic               out_wdst,
    output logic [DATA_W-1:0]  out_a,
    output logic [DATA_W-1:0]  out_b,
    output logic [REG_CNT-1:0] busy
);

    logic wbhit1, wbhit2, wbhitd;
    logic raw1, raw2, waw;
    logic space, accept;
    logic [DATA_W-1:0] op_a, op_b;

    logic              out_valid_q, out_valid_d;
    logic [OP_W-1:0]   out_op_q,    out_op_d;
    logic [SEL_W-1:0]  out_dst_q,   out_dst_d;
    logic              out_wdst_q,  out_wdst_d;
    logic [DATA_W-1:0] out_a_q,     out_a_d;
    logic [DATA_W-1:0] out_b_q,     out_b_d;

    assign r1_select = in_src1;
    assign r2_select = in_src2;

    // The register file commits on the edge, so a writeback this cycle both
    // resolves the hazard and supplies the data.
    assign wbhit1 = wb_w && (wb_select == in_src1);
    assign wbhit2 = wb_w && (wb_select == in_src2);
    assign wbhitd = wb_w && (wb_select == in_dst);

    assign raw1 = in_use1 && busy[in_src1] && !wbhit1;
    assign raw2 = in_use2 && busy[in_src2] && !wbhit2;
    assign waw  = in_wdst && busy[in_dst]  && !wbhitd;

    assign space    = !out_valid_q || out_ready;
    assign in_ready = space && !raw1 && !raw2 && !waw;
    assign accept   = in_valid && in_ready;

    assign op_a = wbhit1 ? wb_data : read1;
    assign op_b = wbhit2 ? wb_data : read2;

    always_comb begin
        out_valid_d = out_valid_q;
        out_op_d    = out_op_q;
        out_dst_d   = out_dst_q;
        out_wdst_d  = out_wdst_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_op_d    = in_op;
            out_dst_d   = in_dst;
            out_wdst_d  = in_wdst;
            out_a_d     = op_a;
            out_b_d     = op_b;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_op_q    <= '0;
            out_dst_q   <= '0;
            out_wdst_q  <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_op_q    <= out_op_d;
            out_dst_q   <= out_dst_d;
            out_wdst_q  <= out_wdst_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op    = out_op_q;
    assign out_dst   = out_dst_q;
    assign out_wdst  = out_wdst_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

    reg_scoreboard #(
        .SEL_W   (SEL_W),
        .REG_CNT (REG_CNT)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .set_i     (accept && in_wdst),
        .set_sel_i (in_dst),
        .clr_i     (wb_w),
        .clr_sel_i (wb_select),
        .busy_o    (busy)
    );

endmodule : operand_fetch_stage

`default_nettype wire

// File: tb/tb_operand_fetch_stage.sv
// ============================================================================
// tb_operand_fetch_stage : directed checks plus a short random scoreboard run
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_operand_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_op;
    logic [3:0]  in_src1, in_src2, in_dst;
    logic        in_use1, in_use2, in_wdst;
    logic [3:0]  r1_select, r2_select;
    logic [19:0] read1, read2;
    logic        wb_w;
    logic [3:0]  wb_select;
    logic [19:0] wb_data;
    logic        out_valid, out_ready;
    logic [4:0]  out_op;
    logic [3:0]  out_dst;
    logic        out_wdst;
    logic [19:0] out_a, out_b;
    logic [15:0] busy;

    logic [19:0] rf [16];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (wb_w) rf[wb_select] <= wb_data;
    assign read1 = rf[r1_select];
    assign read2 = rf[r2_select];

    operand_fetch_stage dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_use1(in_use1), .in_use2(in_use2),
        .in_dst(in_dst), .in_wdst(in_wdst),
        .r1_select(r1_select), .r2_select(r2_select), .read1(read1), .read2(read2),
        .wb_w(wb_w), .wb_select(wb_select), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_dst(out_dst), .out_wdst(out_wdst), .out_a(out_a), .out_b(out_b),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic instr(input logic v, input logic [4:0] op,
                         input logic [3:0] s1, input logic u1,
                         input logic [3:0] s2, input logic u2,
                         input logic [3:0] d, input logic wd);
        in_valid = v; in_op = op;
        in_src1 = s1; in_use1 = u1; in_src2 = s2; in_use2 = u2;
        in_dst = d; in_wdst = wd;
    endtask

    task automatic wb(input logic w, input logic [3:0] sel, input logic [19:0] data);
        wb_w = w; wb_select = sel; wb_data = data;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] m_busy;
    logic        m_ov;
    logic        exp_rdy, m_acc;
    logic [19:0] exp_a, exp_b;

    initial begin
        reset = 1'b0; out_ready = 1'b1;
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        #2;
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_a", 32'(out_a), 32'h0);

        @(negedge clk); reset = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wb(1, 4'(i), 20'(i * 20'h01010));
            @(negedge clk);
        end
        wb(1, 3, 20'h00ABC); @(negedge clk);
        wb(1, 5, 20'h12345); @(negedge clk);
        wb(0, 0, 0);
        check("preload_busy", 32'(busy), 32'h0);

        // Simple issue
        instr(1, 5'h11, 3, 1, 5, 1, 7, 1);
        #1;
        check("simple_in_ready", 32'(in_ready), 32'h1);
        check("simple_r1_select", 32'(r1_select), 32'h3);
        edge_sample();
        check("simple_out_valid", 32'(out_valid), 32'h1);
        check("simple_out_a", 32'(out_a), 32'h00ABC);
        check("simple_out_b", 32'(out_b), 32'h12345);
        check("simple_out_dst", 32'(out_dst), 32'h7);
        check("simple_out_op", 32'(out_op), 32'h11);
        check("simple_busy", 32'(busy), 32'h0080);

        // RAW stall, then resolved by same-cycle writeback with bypass
        @(negedge clk);
        instr(1, 5'h02, 7, 1, 0, 0, 1, 0);
        #1;
        check("raw_in_ready_stall", 32'(in_ready), 32'h0);
        edge_sample();
        check("raw_bubble", 32'(out_valid), 32'h0);
        check("raw_busy_hold", 32'(busy), 32'h0080);
        @(negedge clk);
        wb(1, 7, 20'hFFFFF);
        #1;
        check("raw_in_ready_wb", 32'(in_ready), 32'h1);
        edge_sample();
        check("raw_bypass_a", 32'(out_a), 32'hFFFFF);
        check("raw_out_valid", 32'(out_valid), 32'h1);
        check("raw_busy_clear", 32'(busy), 32'h0);

        // WAW stall; accepted in writeback cycle, set wins
        @(negedge clk);
        wb(0, 0, 0);
        instr(1, 5'h03, 0, 0, 0, 0, 2, 1);
        edge_sample();
        check("waw_first_busy", 32'(busy), 32'h0004);
        @(negedge clk);
        instr(1, 5'h04, 3, 0, 2, 0, 2, 1);
        #1;
        check("waw_in_ready_stall", 32'(in_ready), 32'h0);
        edge_sample();
        check("waw_busy_hold", 32'(busy), 32'h0004);
        check("waw_bubble", 32'(out_valid), 32'h0);
        @(negedge clk);
        wb(1, 2, 20'h55555);
        #1;
        check("waw_in_ready_wb", 32'(in_ready), 32'h1);
        edge_sample();
        check("waw_set_wins", 32'(busy), 32'h0004);
        check("waw_out_dst", 32'(out_dst), 32'h2);
        check("unused_src_a", 32'(out_a), 32'h00ABC);
        check("unused_src_b_bypass", 32'(out_b), 32'h55555);

        // Backpressure for three cycles, then back-to-back transfers
        @(negedge clk);
        wb(0, 0, 0);
        out_ready = 1'b0;
        instr(1, 5'h05, 5, 1, 3, 1, 9, 1);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'h0);
            edge_sample();
            check("bp_out_valid", 32'(out_valid), 32'h1);
            check("bp_out_dst", 32'(out_dst), 32'h2);
            check("bp_out_b", 32'(out_b), 32'h55555);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", 32'(in_ready), 32'h1);
        edge_sample();
        check("bp_xfer_dst", 32'(out_dst), 32'h9);
        check("bp_xfer_a", 32'(out_a), 32'h12345);
        check("bp_xfer_b", 32'(out_b), 32'h00ABC);
        check("bp_busy", 32'(busy), 32'h0204);
        @(negedge clk);
        instr(1, 5'h06, 4, 1, 4, 1, 4, 1);
        wb(1, 4, 20'h0BEEF);
        #1;
        check("b2b_in_ready", 32'(in_ready), 32'h1);
        edge_sample();
        check("b2b_out_valid", 32'(out_valid), 32'h1);
        check("same_src_a", 32'(out_a), 32'h0BEEF);
        check("same_src_b", 32'(out_b), 32'h0BEEF);
        check("rw_same_reg_busy", 32'(busy), 32'h0214);
        @(negedge clk);
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        edge_sample();
        check("drain_out_valid", 32'(out_valid), 32'h0);

        // Random issue/writeback stream against a reference scoreboard
        m_busy = 16'h0214;
        m_ov   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            instr(1'($urandom), 5'($urandom), 4'($urandom), 1'($urandom),
                  4'($urandom), 1'($urandom), 4'($urandom), 1'($urandom));
            wb(($urandom_range(0, 2) != 0), 4'($urandom), 20'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            exp_rdy = (!m_ov || out_ready)
                   && !(in_use1 && m_busy[in_src1] && !(wb_w && wb_select == in_src1))
                   && !(in_use2 && m_busy[in_src2] && !(wb_w && wb_select == in_src2))
                   && !(in_wdst && m_busy[in_dst]  && !(wb_w && wb_select == in_dst));
            exp_a = (wb_w && wb_select == in_src1) ? wb_data : rf[in_src1];
            exp_b = (wb_w && wb_select == in_src2) ? wb_data : rf[in_src2];
            m_acc = in_valid && exp_rdy;
            #1;
            check("rand_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (wb_w) m_busy[wb_select] = 1'b0;
            if (m_acc && in_wdst) m_busy[in_dst] = 1'b1;
            if (m_acc) m_ov = 1'b1;
            else if (out_ready) m_ov = 1'b0;
            edge_sample();
            check("rand_busy", 32'(busy), 32'(m_busy));
            check("rand_out_valid", 32'(out_valid), 32'(m_ov));
            if (m_acc) begin
                check("rand_out_a", 32'(out_a), 32'(exp_a));
                check("rand_out_b", 32'(out_b), 32'(exp_b));
            end
        end

        // Asynchronous reset mid-stream
        @(negedge clk);
        out_ready = 1'b1;
        instr(1, 5'h07, 0, 0, 0, 0, 7, 1);
        wb(1, 7, 20'h00001);
        edge_sample();
        check("pre_reset_out_valid", 32'(out_valid), 32'h1);
        check("pre_reset_busy", 32'(busy), 32'(m_busy | 16'h0080));
        instr(0, 0, 0, 0, 0, 0, 0, 0);
        wb(0, 0, 0);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset_busy", 32'(busy), 32'h0);
        check("async_reset_out_valid", 32'(out_valid), 32'h0);
        check("async_reset_out_dst", 32'(out_dst), 32'h0);
        edge_sample();
        check("reset_held_valid", 32'(out_valid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_operand_fetch_stage

`default_nettype wire
